// File: rtl/maxi_core32.sv
// maxi_core32: non-pipelined 32-bit CPU core, sixteen GPRs, big-endian byte-laned bus.
// Runs from address 0 after reset until HALT, an undefined opcode, or a misaligned access.
//
// state      | meaning
// S_FETCH    | drive PC word address with read, all lanes
// S_DECODE   | latch instruction from data_in, PC += 4
// S_EXECUTE  | register/flag/branch/jump/store actions; loads issue their read here
// S_LOADWAIT | write extracted load data into rA
// S_HALT     | HALT or undefined opcode executed; parked until reset
// S_ERROR    | misaligned access or jump target; parked until reset
module maxi_core32 (
  input  logic        clock,
  input  logic        reset,
  output logic [31:2] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [3:0]  data_strobes,
  output logic        read,
  output logic        write,
  output logic        bus_error,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_LOADWAIT, S_HALT, S_ERROR
  } state_t;

  localparam logic [5:0] OP_NOP    = 6'h00;
  localparam logic [5:0] OP_LOADI  = 6'h02;
  localparam logic [5:0] OP_LOADU  = 6'h03;
  localparam logic [5:0] OP_ALU    = 6'h04;
  localparam logic [5:0] OP_ALUI   = 6'h05;
  localparam logic [5:0] OP_LOADW  = 6'h06;
  localparam logic [5:0] OP_LOADH  = 6'h07;
  localparam logic [5:0] OP_LOADB  = 6'h08;
  localparam logic [5:0] OP_STOREW = 6'h09;
  localparam logic [5:0] OP_STOREH = 6'h0A;
  localparam logic [5:0] OP_STOREB = 6'h0B;
  localparam logic [5:0] OP_BRANCH = 6'h0C;
  localparam logic [5:0] OP_JUMP   = 6'h0D;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] regs [16];
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;

  logic [5:0]  opcode;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic [3:0]  alu_op;
  logic [31:0] imm16_sx;
  logic [31:0] imm14_sx;
  logic [31:0] val_a;
  logic [31:0] val_b;
  logic [31:0] val_c;
  logic [31:0] ea;

  assign opcode   = ir[31:26];
  assign ra       = ir[25:22];
  assign rb       = ir[21:18];
  assign alu_op   = ir[17:14];
  assign rc       = ir[13:10];
  assign imm16_sx = {{16{ir[15]}}, ir[15:0]};
  assign imm14_sx = {{18{ir[13]}}, ir[13:0]};
  assign val_a    = regs[ra];
  assign val_b    = regs[rb];
  assign val_c    = regs[rc];
  assign ea       = val_b + imm16_sx;

  logic is_load;
  logic is_store;
  logic size_word;
  logic size_half;
  logic misaligned;

  assign is_load   = (opcode == OP_LOADW)  || (opcode == OP_LOADH)  || (opcode == OP_LOADB);
  assign is_store  = (opcode == OP_STOREW) || (opcode == OP_STOREH) || (opcode == OP_STOREB);
  assign size_word = (opcode == OP_LOADW)  || (opcode == OP_STOREW);
  assign size_half = (opcode == OP_LOADH)  || (opcode == OP_STOREH);
  assign misaligned = size_word ? (ea[1:0] != 2'b00) :
                      size_half ? ea[0] : 1'b0;

  logic [3:0]  lane_strobes;
  logic [31:0] store_data;
  logic [31:0] load_data;

  // Big-endian lanes: byte offset 0 lives in data[31:24].
  always_comb begin
    lane_strobes = 4'b1111;
    store_data   = val_a;
    if (size_half) begin
      lane_strobes = ea[1] ? 4'b0011 : 4'b1100;
      store_data   = {2{val_a[15:0]}};
    end else if (!size_word) begin
      lane_strobes = 4'b1000 >> ea[1:0];
      store_data   = {4{val_a[7:0]}};
    end
  end

  // Registers are untouched between EXECUTE and LOADWAIT, so ea is still the load address.
  always_comb begin
    load_data = data_in;
    if (opcode == OP_LOADH) begin
      load_data = ea[1] ? {16'h0, data_in[15:0]} : {16'h0, data_in[31:16]};
    end else if (opcode == OP_LOADB) begin
      case (ea[1:0])
        2'd0:    load_data = {24'h0, data_in[31:24]};
        2'd1:    load_data = {24'h0, data_in[23:16]};
        2'd2:    load_data = {24'h0, data_in[15:8]};
        default: load_data = {24'h0, data_in[7:0]};
      endcase
    end
  end

  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        alu_c;
  logic [32:0] wide;

  assign alu_b = (opcode == OP_ALU) ? val_c : imm14_sx;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    wide    = '0;
    case (alu_op)
      4'd0: begin
        wide    = {1'b0, val_b} + {1'b0, alu_b};
        alu_res = wide[31:0];
        alu_c   = wide[32];
      end
      4'd1: begin
        wide    = {1'b0, val_b} - {1'b0, alu_b};
        alu_res = wide[31:0];
        alu_c   = ~wide[32];
      end
      4'd2: alu_res = val_b & alu_b;
      4'd3: alu_res = val_b | alu_b;
      4'd4: alu_res = val_b ^ alu_b;
      4'd5: alu_res = val_b << alu_b[4:0];
      4'd6: alu_res = val_b >> alu_b[4:0];
      4'd7: alu_res = $signed(val_b) >>> alu_b[4:0];
      4'd8: alu_res = val_b;
      default: alu_res = '0;
    endcase
  end

  logic br_take;

  always_comb begin
    case (ra)
      4'd0:    br_take = 1'b1;
      4'd1:    br_take = flag_z;
      4'd2:    br_take = ~flag_z;
      4'd3:    br_take = flag_c;
      4'd4:    br_take = ~flag_c;
      4'd5:    br_take = flag_n;
      4'd6:    br_take = ~flag_n;
      default: br_take = 1'b0;
    endcase
  end

  // The bus is decoded from state so the first fetch is visible in the cycle reset drops.
  always_comb begin
    address      = '0;
    data_out     = '0;
    data_strobes = 4'b0000;
    read         = 1'b0;
    write        = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          address      = pc[31:2];
          data_strobes = 4'b1111;
          read         = 1'b1;
        end
        S_EXECUTE: begin
          if ((is_load || is_store) && !misaligned) begin
            address      = ea[31:2];
            data_strobes = lane_strobes;
            read         = is_load;
            write        = is_store;
            data_out     = is_store ? store_data : 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      halted    <= 1'b0;
      bus_error <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir    <= data_in;
          pc    <= pc + 32'd4;
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          state <= S_FETCH;
          case (opcode)
            OP_NOP:   ;
            OP_LOADI: regs[ra] <= imm16_sx;
            OP_LOADU: regs[ra] <= {ir[15:0], val_a[15:0]};
            OP_ALU, OP_ALUI: begin
              regs[ra] <= alu_res;
              flag_z   <= (alu_res == 32'h0);
              flag_n   <= alu_res[31];
              flag_c   <= alu_c;
            end
            OP_LOADW, OP_LOADH, OP_LOADB,
            OP_STOREW, OP_STOREH, OP_STOREB: begin
              if (misaligned) begin
                bus_error <= 1'b1;
                state     <= S_ERROR;
              end else if (is_load) begin
                state <= S_LOADWAIT;
              end
            end
            // pc already holds branch address + 4.
            OP_BRANCH: if (br_take) pc <= pc + {imm16_sx[29:0], 2'b00};
            OP_JUMP: begin
              if (val_b[1:0] != 2'b00) begin
                bus_error <= 1'b1;
                state     <= S_ERROR;
              end else begin
                regs[ra] <= pc;
                pc       <= val_b;
              end
            end
            default: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
          endcase
        end
        S_LOADWAIT: begin
          regs[ra] <= load_data;
          state    <= S_FETCH;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxi_core32.sv
// Scoreboard bench for maxi_core32: expected store cycles are queued per program,
// a negedge monitor pops and compares them; run status is checked after each program.
module tb_maxi_core32;

  logic        clock;
  logic        reset;
  logic [31:2] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  data_strobes;
  logic        read;
  logic        write;
  logic        bus_error;
  logic        halted;

  maxi_core32 dut (
    .clock(clock), .reset(reset), .address(address), .data_in(data_in),
    .data_out(data_out), .data_strobes(data_strobes), .read(read), .write(write),
    .bus_error(bus_error), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] image [256];
  logic [31:0] mem   [256];
  logic        do_load;

  always @(posedge clock) begin
    if (do_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= image[i];
    end else begin
      if (read) data_in <= mem[address[9:2]];
      if (write)
        for (int b = 0; b < 4; b++)
          if (data_strobes[b]) mem[address[9:2]][8*b +: 8] <= data_out[8*b +: 8];
    end
  end

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q [$];
  int  checks = 0;
  int  errors = 0;
  int  reads  = 0;

  always @(negedge clock) begin
    if (read) reads++;
    if (read || write) begin
      checks++;
      if (read && write) begin
        errors++;
        $display("FAIL bus_excl: read and write both high at %0t", $time);
      end
    end
    if (write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %h strb %b data %h, wanted no write",
                 {address, 2'b00}, data_strobes, data_out);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (address !== e.waddr || data_strobes !== e.strb || data_out !== e.data) begin
          errors++;
          $display("FAIL wr_cycle: got addr %h strb %b data %h, wanted addr %h strb %b data %h",
                   {address, 2'b00}, data_strobes, data_out, {e.waddr, 2'b00}, e.strb, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [15:0] imm);
    return {op, ra, rb, 2'b00, imm};
  endfunction

  function automatic logic [31:0] enc_alu(input logic [3:0] fn, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
    return {6'h04, ra, rb, fn, rc, 10'h000};
  endfunction

  function automatic logic [31:0] enc_alui(input logic [3:0] fn, input logic [3:0] ra,
                                           input logic [3:0] rb, input logic [13:0] imm);
    return {6'h05, ra, rb, fn, imm};
  endfunction

  localparam logic [31:0] HALT = 32'h0400_0000;

  task automatic push_wr(input logic [31:0] byte_addr, input logic [3:0] strb,
                         input logic [31:0] data);
    wr_t e;
    e.waddr = byte_addr[31:2];
    e.strb  = strb;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  task automatic clear_image();
    for (int i = 0; i < 256; i++) image[i] = 32'h0;
  endtask

  task automatic run_prog(input string name, input int exp_cyc, input int exp_reads,
                          input logic exp_halt, input logic exp_err);
    int cyc;
    int reads_at_stop;
    @(negedge clock);
    reset   = 1'b1;
    do_load = 1'b1;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    do_load = 1'b0;
    reads   = 0;
    cyc     = 0;
    while (!(halted || bus_error) && cyc < 400) begin
      @(posedge clock);
      cyc++;
      #1;
    end
    chk({name, "_cycles"}, cyc, exp_cyc);
    chk({name, "_halted"}, {31'h0, halted}, {31'h0, exp_halt});
    chk({name, "_bus_error"}, {31'h0, bus_error}, {31'h0, exp_err});
    reads_at_stop = reads;
    chk({name, "_reads"}, reads_at_stop, exp_reads);
    chk({name, "_wr_missing"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (5) @(posedge clock);
    #1;
    chk({name, "_idle_reads"}, reads, reads_at_stop);
    chk({name, "_sticky"}, {30'h0, halted, bus_error}, {30'h0, exp_halt, exp_err});
  endtask

  initial begin
    reset   = 1'b1;
    do_load = 1'b0;
    data_in = 32'h0;
    clear_image();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_address", {address, 2'b00}, 32'h0);
    chk("rst_bus", {28'h0, read, write, halted, bus_error}, 32'h0);
    chk("rst_strobes", {28'h0, data_strobes}, 32'h0);
    chk("rst_data_out", data_out, 32'h0);

    // Add and store
    clear_image();
    image[0] = enc_i(6'h02, 4'd1, 4'd0, 16'd5);
    image[1] = enc_i(6'h02, 4'd2, 4'd0, 16'd7);
    image[2] = enc_alu(4'd0, 4'd3, 4'd1, 4'd2);
    image[3] = enc_i(6'h09, 4'd3, 4'd0, 16'h0040);
    image[4] = HALT;
    push_wr(32'h40, 4'b1111, 32'h0000_000C);
    run_prog("add", 15, 5, 1'b1, 1'b0);
    chk("add_mem40", mem[16], 32'h0000_000C);

    // LOADUPPER over a sign-extended LOADI
    clear_image();
    image[0] = enc_i(6'h02, 4'd1, 4'd0, 16'hFFFF);
    image[1] = enc_i(6'h03, 4'd1, 4'd0, 16'h1234);
    image[2] = enc_i(6'h09, 4'd1, 4'd0, 16'h0044);
    image[3] = HALT;
    push_wr(32'h44, 4'b1111, 32'h1234_FFFF);
    run_prog("loadu", 12, 4, 1'b1, 1'b0);
    chk("loadu_mem44", mem[17], 32'h1234_FFFF);

    // Byte/halfword lanes, big-endian
    clear_image();
    image[0]  = enc_i(6'h02, 4'd4, 4'd0, 16'h00AB);
    image[1]  = enc_i(6'h0B, 4'd4, 4'd0, 16'h0041);
    image[2]  = enc_i(6'h08, 4'd5, 4'd0, 16'h0041);
    image[3]  = enc_i(6'h09, 4'd5, 4'd0, 16'h0048);
    image[4]  = enc_i(6'h02, 4'd6, 4'd0, 16'h5678);
    image[5]  = enc_i(6'h0A, 4'd6, 4'd0, 16'h004E);
    image[6]  = enc_i(6'h07, 4'd7, 4'd0, 16'h004C);
    image[7]  = enc_i(6'h09, 4'd7, 4'd0, 16'h0050);
    image[8]  = HALT;
    image[16] = 32'h1122_3344;
    image[19] = 32'hAAAA_BBBB;
    push_wr(32'h40, 4'b0100, 32'hABAB_ABAB);
    push_wr(32'h48, 4'b1111, 32'h0000_00AB);
    push_wr(32'h4C, 4'b0011, 32'h5678_5678);
    push_wr(32'h50, 4'b1111, 32'h0000_AAAA);
    run_prog("lanes", 29, 11, 1'b1, 1'b0);
    chk("lanes_mem40", mem[16], 32'h11AB_3344);
    chk("lanes_mem4c", mem[19], 32'hAAAA_5678);

    // SUB then BRANCH Z: taken (3-3) and not taken (3-4)
    for (int k = 0; k < 2; k++) begin
      clear_image();
      image[0] = enc_i(6'h02, 4'd1, 4'd0, 16'd3);
      image[1] = enc_i(6'h02, 4'd2, 4'd0, (k == 0) ? 16'd3 : 16'd4);
      image[2] = enc_alu(4'd1, 4'd3, 4'd1, 4'd2);
      image[3] = enc_i(6'h0C, 4'd1, 4'd0, 16'h0001);
      image[4] = enc_i(6'h02, 4'd4, 4'd0, 16'd1);
      image[5] = enc_i(6'h02, 4'd5, 4'd0, 16'd2);
      image[6] = enc_i(6'h09, 4'd4, 4'd0, 16'h0040);
      image[7] = enc_i(6'h09, 4'd5, 4'd0, 16'h0044);
      image[8] = HALT;
      push_wr(32'h40, 4'b1111, (k == 0) ? 32'h0 : 32'h1);
      push_wr(32'h44, 4'b1111, 32'h2);
      run_prog((k == 0) ? "br_taken" : "br_not", (k == 0) ? 24 : 27,
               (k == 0) ? 8 : 9, 1'b1, 1'b0);
    end

    // Shifts, carry branch, JUMP with rA == rB
    clear_image();
    image[0]  = enc_i(6'h02, 4'd1, 4'd0, 16'hFFF0);
    image[1]  = enc_alui(4'd7, 4'd2, 4'd1, 14'd2);
    image[2]  = enc_alui(4'd6, 4'd3, 4'd1, 14'd4);
    image[3]  = enc_i(6'h09, 4'd2, 4'd0, 16'h0040);
    image[4]  = enc_i(6'h09, 4'd3, 4'd0, 16'h0044);
    image[5]  = enc_alui(4'd0, 4'd4, 4'd1, 14'h0010);
    image[6]  = enc_i(6'h0C, 4'd3, 4'd0, 16'h0001);
    image[7]  = HALT;
    image[8]  = enc_i(6'h02, 4'd9, 4'd0, 16'h0030);
    image[9]  = enc_i(6'h0D, 4'd9, 4'd9, 16'h0000);
    image[10] = HALT;
    image[11] = HALT;
    image[12] = enc_i(6'h09, 4'd9, 4'd0, 16'h0048);
    image[13] = HALT;
    push_wr(32'h40, 4'b1111, 32'hFFFF_FFFC);
    push_wr(32'h44, 4'b1111, 32'h0FFF_FFFF);
    push_wr(32'h48, 4'b1111, 32'h0000_0028);
    run_prog("shift_jump", 33, 11, 1'b1, 1'b0);

    // Misaligned LOADW, then one-cycle reset recovery
    clear_image();
    image[0] = enc_i(6'h06, 4'd2, 4'd0, 16'h0042);
    run_prog("misalign", 3, 1, 1'b0, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("recover_bus_error", {31'h0, bus_error}, 32'h0);
    chk("recover_read", {31'h0, read}, 32'h1);
    chk("recover_address", {address, 2'b00}, 32'h0);

    // Undefined opcode behaves as HALT
    clear_image();
    image[0] = 32'hFC00_0000;
    run_prog("undef", 3, 1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
